// File: rtl/i2c_target.sv
// I2C target (responder) with 7-bit addressing and a byte-wide register port.
// Oversamples SCL/SDA on clk; START/STOP are decoded in every state.
// Optional: define I2C_GLITCH_FILTER_EN to add a 3-sample majority filter
// on both synchronized lines (rejects 1-clk pulses, adds 1 clk of latency).
module i2c_target #(
  parameter logic [6:0]  TARGET_ADDR = 7'h44,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_oe,
  output logic [7:0] reg_ptr,
  output logic       wr_en,
  output logic [7:0] wr_data,
  output logic       rd_req,
  input  logic [7:0] rd_data,
  output logic       busy,
  output logic       addr_hit
);

  localparam int unsigned CNT_W = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_ADDR_ACK,
    S_WR_BYTE,
    S_WR_ACK,
    S_RD_BYTE,
    S_RD_ACK,
    S_WAIT_STOP
  } state_e;

  // ---------------------------------------------------------------------
  // Input conditioning
  // ---------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d;
  logic [SYNC_STAGES-1:0] sda_sync_q, sda_sync_d;
  logic                   s_scl, s_sda;
  logic                   scl_prev_q, scl_prev_d;
  logic                   sda_prev_q, sda_prev_d;

  // Synchronizer shift and delayed copies for edge detection
  always_comb begin
    scl_sync_d = {scl_sync_q[SYNC_STAGES-2:0], scl_i};
    sda_sync_d = {sda_sync_q[SYNC_STAGES-2:0], sda_i};
    scl_prev_d = s_scl;
    sda_prev_d = s_sda;
  end

`ifdef I2C_GLITCH_FILTER_EN
  logic [1:0] scl_hist_q, scl_hist_d;
  logic [1:0] sda_hist_q, sda_hist_d;
  logic       scl_raw, sda_raw;

  // Majority of the current synced sample and the two before it
  always_comb begin
    scl_raw    = scl_sync_q[SYNC_STAGES-1];
    sda_raw    = sda_sync_q[SYNC_STAGES-1];
    scl_hist_d = {scl_hist_q[0], scl_raw};
    sda_hist_d = {sda_hist_q[0], sda_raw};
    s_scl = (scl_raw & scl_hist_q[0]) | (scl_raw & scl_hist_q[1]) | (scl_hist_q[0] & scl_hist_q[1]);
    s_sda = (sda_raw & sda_hist_q[0]) | (sda_raw & sda_hist_q[1]) | (sda_hist_q[0] & sda_hist_q[1]);
  end

  // Filter history registers (idle bus is high)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_hist_q <= 2'b11;
      sda_hist_q <= 2'b11;
    end else begin
      scl_hist_q <= scl_hist_d;
      sda_hist_q <= sda_hist_d;
    end
  end
`else
  // Synced lines used directly
  always_comb begin
    s_scl = scl_sync_q[SYNC_STAGES-1];
    s_sda = sda_sync_q[SYNC_STAGES-1];
  end
`endif

  // Synchronizer and edge-detect registers (idle bus is high)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_sync_q <= scl_sync_d;
      sda_sync_q <= sda_sync_d;
      scl_prev_q <= scl_prev_d;
      sda_prev_q <= sda_prev_d;
    end
  end

  logic scl_rise, scl_fall, start_det, stop_det;

  // Bus events on the conditioned lines
  always_comb begin
    scl_rise  =  s_scl & ~scl_prev_q;
    scl_fall  = ~s_scl &  scl_prev_q;
    start_det =  s_scl &  scl_prev_q &  sda_prev_q & ~s_sda;
    stop_det  =  s_scl &  scl_prev_q & ~sda_prev_q &  s_sda;
  end

  // ---------------------------------------------------------------------
  // Protocol FSM
  // ---------------------------------------------------------------------
  state_e           state_q, state_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       tx_q, tx_d;
  logic             ack_ph_q, ack_ph_d;
  logic             first_byte_q, first_byte_d;
  logic             rw_q, rw_d;
  logic             sda_oe_q, sda_oe_d;
  logic [7:0]       reg_ptr_q, reg_ptr_d;
  logic             wr_en_q, wr_en_d;
  logic [7:0]       wr_data_q, wr_data_d;
  logic             rd_req_q, rd_req_d;
  logic             busy_q, busy_d;
  logic             addr_hit_q, addr_hit_d;
  logic [7:0]       byte_in;

  // Next-state and output logic
  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    tx_d         = tx_q;
    ack_ph_d     = ack_ph_q;
    first_byte_d = first_byte_q;
    rw_d         = rw_q;
    sda_oe_d     = sda_oe_q;
    reg_ptr_d    = reg_ptr_q;
    wr_en_d      = 1'b0;
    wr_data_d    = wr_data_q;
    rd_req_d     = 1'b0;
    busy_d       = busy_q;
    addr_hit_d   = addr_hit_q;
    byte_in      = {shift_q[6:0], s_sda};

    // Read byte is captured one clk after the request strobe
    if (rd_req_q) tx_d = rd_data;
    // Pointer advances the cycle after a data write strobe
    if (wr_en_q) reg_ptr_d = reg_ptr_q + 8'd1;

    if (start_det) begin
      state_d    = S_ADDR;
      bit_cnt_d  = '0;
      busy_d     = 1'b1;
      addr_hit_d = 1'b0;
      sda_oe_d   = 1'b0;
    end else if (stop_det) begin
      state_d    = S_IDLE;
      busy_d     = 1'b0;
      addr_hit_d = 1'b0;
      sda_oe_d   = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: ;
        S_ADDR: begin
          if (scl_rise) begin
            shift_d = byte_in;
            if (bit_cnt_q == CNT_W'(7)) begin
              bit_cnt_d = '0;
              if (byte_in[7:1] == TARGET_ADDR) begin
                state_d  = S_ADDR_ACK;
                ack_ph_d = 1'b0;
                rw_d     = byte_in[0];
                rd_req_d = byte_in[0];
              end else begin
                state_d = S_WAIT_STOP;
              end
            end else begin
              bit_cnt_d = bit_cnt_q + CNT_W'(1);
            end
          end
        end
        S_ADDR_ACK: begin
          if (scl_fall) begin
            if (!ack_ph_q) begin
              sda_oe_d   = 1'b1;
              addr_hit_d = 1'b1;
              ack_ph_d   = 1'b1;
            end else if (rw_q) begin
              sda_oe_d  = ~tx_q[7];
              tx_d      = {tx_q[6:0], 1'b0};
              bit_cnt_d = CNT_W'(1);
              state_d   = S_RD_BYTE;
            end else begin
              sda_oe_d     = 1'b0;
              first_byte_d = 1'b1;
              bit_cnt_d    = '0;
              state_d      = S_WR_BYTE;
            end
          end
        end
        S_WR_BYTE: begin
          if (scl_rise) begin
            shift_d = byte_in;
            if (bit_cnt_q == CNT_W'(7)) begin
              if (first_byte_q) begin
                reg_ptr_d    = byte_in;
                first_byte_d = 1'b0;
              end else begin
                wr_data_d = byte_in;
                wr_en_d   = 1'b1;
              end
              bit_cnt_d = '0;
              ack_ph_d  = 1'b0;
              state_d   = S_WR_ACK;
            end else begin
              bit_cnt_d = bit_cnt_q + CNT_W'(1);
            end
          end
        end
        S_WR_ACK: begin
          if (scl_fall) begin
            if (!ack_ph_q) begin
              sda_oe_d = 1'b1;
              ack_ph_d = 1'b1;
            end else begin
              sda_oe_d  = 1'b0;
              bit_cnt_d = '0;
              state_d   = S_WR_BYTE;
            end
          end
        end
        S_RD_BYTE: begin
          if (scl_fall) begin
            if (bit_cnt_q == CNT_W'(8)) begin
              sda_oe_d = 1'b0;
              state_d  = S_RD_ACK;
            end else begin
              sda_oe_d  = ~tx_q[7];
              tx_d      = {tx_q[6:0], 1'b0};
              bit_cnt_d = bit_cnt_q + CNT_W'(1);
            end
          end
        end
        S_RD_ACK: begin
          if (scl_rise) begin
            if (!s_sda) begin
              reg_ptr_d = reg_ptr_q + 8'd1;
              rd_req_d  = 1'b1;
              bit_cnt_d = '0;
              state_d   = S_RD_BYTE;
            end else begin
              state_d = S_WAIT_STOP;
            end
          end
        end
        S_WAIT_STOP: sda_oe_d = 1'b0;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // FSM state and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      tx_q         <= '0;
      ack_ph_q     <= 1'b0;
      first_byte_q <= 1'b0;
      rw_q         <= 1'b0;
      sda_oe_q     <= 1'b0;
      reg_ptr_q    <= '0;
      wr_en_q      <= 1'b0;
      wr_data_q    <= '0;
      rd_req_q     <= 1'b0;
      busy_q       <= 1'b0;
      addr_hit_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      tx_q         <= tx_d;
      ack_ph_q     <= ack_ph_d;
      first_byte_q <= first_byte_d;
      rw_q         <= rw_d;
      sda_oe_q     <= sda_oe_d;
      reg_ptr_q    <= reg_ptr_d;
      wr_en_q      <= wr_en_d;
      wr_data_q    <= wr_data_d;
      rd_req_q     <= rd_req_d;
      busy_q       <= busy_d;
      addr_hit_q   <= addr_hit_d;
    end
  end

  assign sda_oe   = sda_oe_q;
  assign reg_ptr  = reg_ptr_q;
  assign wr_en    = wr_en_q;
  assign wr_data  = wr_data_q;
  assign rd_req   = rd_req_q;
  assign busy     = busy_q;
  assign addr_hit = addr_hit_q;

endmodule

// File: tb/tb_i2c_target.sv
// Directed bench for i2c_target: bus-level initiator model driving an
// open-drain SDA, register-port monitor, immediate-assertion checks.
module tb_i2c_target;

  localparam int Q = 6;  // clk cycles per quarter SCL period

  logic       clk = 1'b0;
  logic       rst;
  logic       scl_m, sda_m;
  logic       scl_i, sda_i;
  logic       sda_oe;
  logic [7:0] reg_ptr;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       rd_req;
  logic [7:0] rd_data;
  logic       busy;
  logic       addr_hit;

  int total = 0;
  int bad   = 0;
  int wr_cnt = 0;
  int rd_cnt = 0;
  logic [7:0] wr_ptr_log [16];
  logic [7:0] wr_dat_log [16];

  always #5 clk = ~clk;

  assign scl_i   = scl_m;
  assign sda_i   = sda_m & ~sda_oe;
  assign rd_data = reg_ptr ^ 8'hFF;

  i2c_target #(.TARGET_ADDR(7'h44), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .scl_i(scl_i), .sda_i(sda_i), .sda_oe(sda_oe),
    .reg_ptr(reg_ptr), .wr_en(wr_en), .wr_data(wr_data), .rd_req(rd_req),
    .rd_data(rd_data), .busy(busy), .addr_hit(addr_hit)
  );

  // Register-port monitor, sampled away from the active edge
  always @(negedge clk) begin
    if (wr_en) begin
      wr_ptr_log[wr_cnt[3:0]] = reg_ptr;
      wr_dat_log[wr_cnt[3:0]] = wr_data;
      wr_cnt++;
    end
    if (rd_req) rd_cnt++;
  end

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic qw();
    repeat (Q) @(negedge clk);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; scl_m = 1'b1; qw();
    sda_m = 1'b0; qw();
    scl_m = 1'b0; qw();
  endtask

  task automatic i2c_rstart();
    sda_m = 1'b1; qw();
    scl_m = 1'b1; qw();
    sda_m = 1'b0; qw();
    scl_m = 1'b0; qw();
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; qw();
    scl_m = 1'b1; qw();
    sda_m = 1'b1; qw(); qw();
  endtask

  // One bit from the initiator; g injects a 1-clk low pulse mid SCL-high
  task automatic put_bit(input logic b, input logic g);
    sda_m = b; qw();
    scl_m = 1'b1;
    if (g) begin
      qw();
      sda_m = 1'b0; @(negedge clk);
      sda_m = b; repeat (Q - 1) @(negedge clk);
    end else begin
      qw(); qw();
    end
    scl_m = 1'b0; qw();
  endtask

  task automatic get_bit(output logic b);
    sda_m = 1'b1; qw();
    scl_m = 1'b1; qw();
    b = sda_i; qw();
    scl_m = 1'b0; qw();
  endtask

  task automatic write_byte(input logic [7:0] d, input int gbit, output logic ack);
    for (int i = 7; i >= 0; i--) put_bit(d[i], i == gbit);
    get_bit(ack);
  endtask

  task automatic read_byte(output logic [7:0] d, input logic nack);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      get_bit(b);
      d[i] = b;
    end
    put_bit(nack, 1'b0);
  endtask

  // Watchdog: the run is a fixed-length directed sequence
  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic       a0, a1, a2, a3;
    logic [7:0] d0, d1, d2;
    int         wb, rb;

    scl_m = 1'b1; sda_m = 1'b1; rst = 1'b1;
    repeat (4) @(negedge clk);
    chk("rst_sda_oe", 8'(sda_oe), 8'h00);
    chk("rst_reg_ptr", reg_ptr, 8'h00);
    chk("rst_wr_en", 8'(wr_en), 8'h00);
    chk("rst_wr_data", wr_data, 8'h00);
    chk("rst_rd_req", 8'(rd_req), 8'h00);
    chk("rst_busy", 8'(busy), 8'h00);
    chk("rst_addr_hit", 8'(addr_hit), 8'h00);
    rst = 1'b0;
    qw();

    // Foreign address 0x45 is NACKed, bus stays busy until STOP
    wb = wr_cnt;
    i2c_start();
    write_byte(8'h8A, -1, a0);
    chk("wrong_addr_nack", 8'(a0), 8'h01);
    chk("wrong_addr_busy", 8'(busy), 8'h01);
    chk("wrong_addr_hit", 8'(addr_hit), 8'h00);
    i2c_stop();
    chk("wrong_addr_busy_after_stop", 8'(busy), 8'h00);
    chk("wrong_addr_no_wr", 8'(wr_cnt - wb), 8'h00);

    // Pointer write then two data bytes
    wb = wr_cnt;
    i2c_start();
    write_byte(8'h88, -1, a0);
    write_byte(8'h10, -1, a1);
    write_byte(8'hA5, -1, a2);
    write_byte(8'h5A, -1, a3);
    chk("wr_ack0", 8'(a0), 8'h00);
    chk("wr_ack1", 8'(a1), 8'h00);
    chk("wr_ack2", 8'(a2), 8'h00);
    chk("wr_ack3", 8'(a3), 8'h00);
    chk("wr_addr_hit", 8'(addr_hit), 8'h01);
    i2c_stop();
    chk("wr_count", 8'(wr_cnt - wb), 8'h02);
    chk("wr0_ptr", wr_ptr_log[wb[3:0]], 8'h10);
    chk("wr0_data", wr_dat_log[wb[3:0]], 8'hA5);
    chk("wr1_ptr", wr_ptr_log[4'(wb + 1)], 8'h11);
    chk("wr1_data", wr_dat_log[4'(wb + 1)], 8'h5A);
    chk("wr_final_ptr", reg_ptr, 8'h12);
    chk("wr_busy_after_stop", 8'(busy), 8'h00);
    chk("wr_hit_after_stop", 8'(addr_hit), 8'h00);

    // Pointer write, repeated START, 3-byte read
    rb = rd_cnt;
    i2c_start();
    write_byte(8'h88, -1, a0);
    write_byte(8'h20, -1, a1);
    i2c_rstart();
    write_byte(8'h89, -1, a2);
    chk("rd_ack_addr_w", 8'(a0), 8'h00);
    chk("rd_ack_ptr", 8'(a1), 8'h00);
    chk("rd_ack_addr_r", 8'(a2), 8'h00);
    read_byte(d0, 1'b0);
    read_byte(d1, 1'b0);
    read_byte(d2, 1'b1);
    chk("rd_byte0", d0, 8'hDF);
    chk("rd_byte1", d1, 8'hDE);
    chk("rd_byte2", d2, 8'hDD);
    chk("rd_sda_released", 8'(sda_oe), 8'h00);
    chk("rd_req_count", 8'(rd_cnt - rb), 8'h03);
    i2c_stop();
    chk("rd_final_ptr", reg_ptr, 8'h22);

    // NACK recovery: foreign address immediately followed by a valid write
    wb = wr_cnt;
    i2c_start();
    write_byte(8'h8A, -1, a0);
    i2c_stop();
    i2c_start();
    write_byte(8'h88, -1, a1);
    write_byte(8'h00, -1, a2);
    write_byte(8'h33, -1, a3);
    i2c_stop();
    chk("rec_nack", 8'(a0), 8'h01);
    chk("rec_ack_addr", 8'(a1), 8'h00);
    chk("rec_ack_data", 8'(a3), 8'h00);
    chk("rec_wr_count", 8'(wr_cnt - wb), 8'h01);
    chk("rec_wr_ptr", wr_ptr_log[wb[3:0]], 8'h00);
    chk("rec_wr_data", wr_dat_log[wb[3:0]], 8'h33);

    // Asynchronous reset while the target is driving the address ACK
    i2c_start();
    for (int i = 7; i >= 0; i--) put_bit(1'(8'h88 >> i), 1'b0);
    sda_m = 1'b1; qw();
    scl_m = 1'b1; qw();
    chk("mid_ack_sda_oe", 8'(sda_oe), 8'h01);
    chk("mid_ack_hit", 8'(addr_hit), 8'h01);
    rst = 1'b1;
    #1;
    chk("arst_sda_oe", 8'(sda_oe), 8'h00);
    chk("arst_reg_ptr", reg_ptr, 8'h00);
    chk("arst_wr_data", wr_data, 8'h00);
    chk("arst_busy", 8'(busy), 8'h00);
    chk("arst_addr_hit", 8'(addr_hit), 8'h00);
    @(negedge clk);
    rst = 1'b0;
    qw();
    wb = wr_cnt;
    i2c_start();
    write_byte(8'h88, -1, a0);
    write_byte(8'h05, -1, a1);
    write_byte(8'h66, -1, a2);
    i2c_stop();
    chk("post_rst_ack", 8'(a0), 8'h00);
    chk("post_rst_wr_count", 8'(wr_cnt - wb), 8'h01);
    chk("post_rst_wr_ptr", wr_ptr_log[wb[3:0]], 8'h05);
    chk("post_rst_wr_data", wr_dat_log[wb[3:0]], 8'h66);

    // 1-clk SDA low glitch during SCL high in the MSB of a data byte
    wb = wr_cnt;
    i2c_start();
    write_byte(8'h88, -1, a0);
    write_byte(8'h30, -1, a1);
    write_byte(8'hC3, 7, a2);
`ifdef I2C_GLITCH_FILTER_EN
    chk("glitch_ack", 8'(a2), 8'h00);
    chk("glitch_hit", 8'(addr_hit), 8'h01);
    chk("glitch_wr_count", 8'(wr_cnt - wb), 8'h01);
    chk("glitch_wr_ptr", wr_ptr_log[wb[3:0]], 8'h30);
    chk("glitch_wr_data", wr_dat_log[wb[3:0]], 8'hC3);
`else
    chk("glitch_nack", 8'(a2), 8'h01);
    chk("glitch_hit", 8'(addr_hit), 8'h00);
    chk("glitch_wr_count", 8'(wr_cnt - wb), 8'h00);
`endif
    i2c_stop();
    chk("glitch_busy_after_stop", 8'(busy), 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
